// File: rtl/trail_history_port.sv
// trail_history_port
//   Memory-side partner of the trail IIR filter for one pixel stream.
//   Issues history-buffer reads at the frame address of each camera pixel,
//   delay-aligns the camera pixel with the returned history pixel, and
//   writes the filter's updates back to the addresses they were read from
//   through an address-tag FIFO.
//
// Ports
//   clk_in, rst_in                 clock, async active-high reset
//   cam_valid_in / cam_frame_start_in / cam_pixel_in   camera stream
//   rd_addr_out, rd_data_in        history BRAM read port
//   valid_out, camera_out, history_out                 aligned pair to filter
//   update_valid_in, update_in     filter result stream
//   wr_en_out, wr_addr_out, wr_data_out                history BRAM write port
//   overflow_err_out               sticky, tag push while FIFO full
//   underflow_err_out              sticky, update while FIFO empty
module trail_history_port #(
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 180,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int TAG_DEPTH    = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cam_valid_in,
  input  logic                  cam_frame_start_in,
  input  logic [23:0]           cam_pixel_in,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [23:0]           rd_data_in,
  output logic                  valid_out,
  output logic [23:0]           camera_out,
  output logic [23:0]           history_out,
  input  logic                  update_valid_in,
  input  logic [23:0]           update_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [23:0]           wr_data_out,
  output logic                  overflow_err_out,
  output logic                  underflow_err_out
);

  localparam int                    FRAME     = H_PIXELS * V_PIXELS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME - 1);
  localparam int                    TW        = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [TW-1:0]         TAG_LAST  = TW'(TAG_DEPTH - 1);
  localparam logic [TW:0]           TAG_FULL  = (TW+1)'(TAG_DEPTH);

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [23:0]           data;
  } wr_req_t;

  // ---------------------------------------------------------------- read address
  logic [ADDR_WIDTH-1:0] rd_ptr, last_addr, use_addr;

  // Frame start forces address 0 for this pixel; rd_ptr then follows as use_addr+1.
  assign use_addr    = cam_frame_start_in ? '0 : rd_ptr;
  assign rd_addr_out = cam_valid_in ? use_addr : last_addr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr    <= '0;
      last_addr <= '0;
    end else if (cam_valid_in) begin
      last_addr <= use_addr;
      rd_ptr    <= (use_addr == LAST_ADDR) ? '0 : use_addr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- alignment
  // vld_pipe[k] / pix_pipe[k] carry the camera side k+1 cycles late, so the last
  // stage lines up with BRAM data for the same address.
  logic [READ_LATENCY-1:0]       vld_pipe;
  logic [READ_LATENCY-1:0][23:0] pix_pipe;
  logic [23:0]                   hist_hold;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe  <= '0;
      pix_pipe  <= '0;
      hist_hold <= '0;
    end else begin
      vld_pipe[0] <= cam_valid_in;
      if (cam_valid_in) pix_pipe[0] <= cam_pixel_in;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) pix_pipe[k] <= pix_pipe[k-1];
      end
      if (vld_pipe[READ_LATENCY-1]) hist_hold <= rd_data_in;
    end
  end

  // History arrives from the BRAM in the same cycle as the delayed valid; it is
  // passed straight through then and held from the capture register otherwise.
  assign valid_out   = vld_pipe[READ_LATENCY-1];
  assign camera_out  = pix_pipe[READ_LATENCY-1];
  assign history_out = valid_out ? rd_data_in : hist_hold;

  // ---------------------------------------------------------------- tag FIFO
  logic [ADDR_WIDTH-1:0] tag_mem [TAG_DEPTH];
  logic [TW-1:0]         wp, rp;
  logic [TW:0]           cnt;
  logic                  tag_empty, tag_full, pop_ok, push_ok;

  assign tag_empty = (cnt == '0);
  assign tag_full  = (cnt == TAG_FULL);
  // Pop is judged on the pre-cycle occupancy, so a push into an empty FIFO
  // cannot be popped in the same cycle; a pop frees room for a push when full.
  assign pop_ok    = update_valid_in & ~tag_empty;
  assign push_ok   = cam_valid_in & (~tag_full | pop_ok);

  wr_req_t wr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
      wp                <= '0;
      rp                <= '0;
      cnt               <= '0;
      wr_q              <= '0;
      overflow_err_out  <= 1'b0;
      underflow_err_out <= 1'b0;
    end else begin
      if (push_ok) begin
        tag_mem[wp] <= rd_addr_out;
        wp          <= (wp == TAG_LAST) ? '0 : wp + 1'b1;
      end
      if (pop_ok) rp <= (rp == TAG_LAST) ? '0 : rp + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      wr_q.en <= pop_ok;
      if (pop_ok) begin
        wr_q.addr <= tag_mem[rp];
        wr_q.data <= update_in;
      end

      if (cam_valid_in & ~push_ok)         overflow_err_out  <= 1'b1;
      if (update_valid_in & tag_empty)     underflow_err_out <= 1'b1;
    end
  end

  assign wr_en_out   = wr_q.en;
  assign wr_addr_out = wr_q.addr;
  assign wr_data_out = wr_q.data;

endmodule

// File: tb/tb_trail_history_port.sv
// Randomized and directed bench for trail_history_port against a cycle-level
// reference model (address counter, latency queue, tag queue, BRAM function).
module tb_trail_history_port;

  localparam int H     = 320;
  localparam int V     = 180;
  localparam int AW    = 16;
  localparam int RL    = 2;
  localparam int TD    = 8;
  localparam int FRAME = H * V;

  logic          clk_in, rst_in;
  logic          cam_valid, cam_fs;
  logic [23:0]   cam_pix;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic          valid_o;
  logic [23:0]   cam_o, hist_o;
  logic          uv;
  logic [23:0]   ud;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          ovf, unf;

  trail_history_port #(
    .H_PIXELS(H), .V_PIXELS(V), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .TAG_DEPTH(TD)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cam_valid_in(cam_valid), .cam_frame_start_in(cam_fs), .cam_pixel_in(cam_pix),
    .rd_addr_out(rd_addr), .rd_data_in(rd_data),
    .valid_out(valid_o), .camera_out(cam_o), .history_out(hist_o),
    .update_valid_in(uv), .update_in(ud),
    .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .overflow_err_out(ovf), .underflow_err_out(unf)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // History BRAM: fixed contents, RL-cycle read pipeline.
  function automatic logic [23:0] bram_f(int a);
    return 24'((a * 40503) ^ 32'h00A5C3);
  endfunction

  logic [23:0] bpipe [RL];
  always @(posedge clk_in) begin
    bpipe[0] <= bram_f(int'(rd_addr));
    for (int k = 1; k < RL; k++) bpipe[k] <= bpipe[k-1];
  end
  assign rd_data = bpipe[RL-1];

  // ---------------------------------------------------------------- model
  typedef struct { bit v; logic [23:0] p; int a; } ent_t;

  int          n_chk, n_err;
  int          m_ptr, m_last;
  int          tagq[$];
  ent_t        dl[$];
  bit          m_ovf, m_unf;
  logic [23:0] held_cam, held_hist;
  bit          nx_en;
  int          nx_addr;
  logic [23:0] nx_data;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_last = 0;
    tagq.delete();
    dl.delete();
    repeat (RL) dl.push_back(ent_t'{v: 1'b0, p: 24'h0, a: 0});
    m_ovf = 0; m_unf = 0;
    held_cam = '0; held_hist = '0;
    nx_en = 0; nx_addr = 0; nx_data = '0;
  endtask

  task automatic drive_idle();
    cam_valid = 0; cam_fs = 0; cam_pix = '0; uv = 0; ud = '0;
  endtask

  // One clock: drive after the edge, check on the falling edge, then advance
  // the model by the edge that will sample these inputs.
  task automatic cycle(bit v, bit fs, logic [23:0] p, bit u, logic [23:0] d);
    int          au, pre;
    bit          popped;
    ent_t        e;
    logic [23:0] ec, eh;
    @(posedge clk_in); #1;
    cam_valid = v; cam_fs = fs; cam_pix = p; uv = u; ud = d;
    au = fs ? 0 : m_ptr;
    @(negedge clk_in);
    chk("rd_addr", 32'(rd_addr), 32'(v ? au : m_last));
    e  = dl[0];
    ec = e.v ? e.p : held_cam;
    eh = e.v ? bram_f(e.a) : held_hist;
    chk("valid_out", 32'(valid_o), 32'(e.v));
    chk("camera_out", 32'(cam_o), 32'(ec));
    chk("history_out", 32'(hist_o), 32'(eh));
    chk("wr_en", 32'(wr_en), 32'(nx_en));
    if (nx_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(nx_addr));
      chk("wr_data", 32'(wr_data), 32'(nx_data));
    end
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));

    held_cam = ec; held_hist = eh;
    void'(dl.pop_front());
    dl.push_back(ent_t'{v: v, p: p, a: au});
    pre = tagq.size(); popped = 0; nx_en = 0;
    if (u) begin
      if (pre == 0) m_unf = 1;
      else begin
        nx_en = 1; nx_addr = tagq.pop_front(); nx_data = d; popped = 1;
      end
    end
    if (v) begin
      if (pre == TD && !popped) m_ovf = 1;
      else tagq.push_back(au);
      m_last = au;
      m_ptr  = (au + 1) % FRAME;
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_valid"},   32'(valid_o), 0);
    chk({tag, "_cam"},     32'(cam_o), 0);
    chk({tag, "_hist"},    32'(hist_o), 0);
    chk({tag, "_wr_en"},   32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_ovf"},     32'(ovf), 0);
    chk({tag, "_unf"},     32'(unf), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in = 1; drive_idle(); model_reset();
    @(posedge clk_in); @(posedge clk_in); #2;
    rst_in = 0;
    @(negedge clk_in);
    check_all_zero("reset");
  endtask

  // Reset asserted between edges while the stream is active.
  task automatic async_rst();
    @(posedge clk_in); #3;
    rst_in = 1;
    #1;
    check_all_zero("async_rst");
    drive_idle(); model_reset();
    @(posedge clk_in); @(posedge clk_in); #2;
    rst_in = 0;
  endtask

  initial begin
    #6_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst_in = 1; drive_idle(); model_reset();

    // 5 pixels from frame start, 2-cycle filter model returning history+1
    do_reset();
    for (int c = 0; c < 12; c++)
      cycle(c < 5, c == 0, 24'h100000 + 24'(c),
            (c >= 4 && c < 9), bram_f((c >= 4 && c < 9) ? c - 4 : 0) + 24'd1);

    // full-frame wrap, then mid-frame frame start at rd_ptr=100
    do_reset();
    for (int c = 0; c < FRAME; c++) cycle(1, 0, 24'($urandom), 1, 24'($urandom));
    cycle(1, 0, 24'h0ABCDE, 1, 24'h111111);                 // wraps to 0
    for (int c = 0; c < 99; c++) cycle(1, 0, 24'($urandom), 1, 24'($urandom));
    cycle(1, 1, 24'h0F0F0F, 1, 24'h222222);                 // frame start -> 0
    cycle(1, 0, 24'h0E0E0E, 1, 24'h333333);                 // -> 1
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 1, 24'($urandom));

    // overflow then underflow
    do_reset();
    for (int c = 0; c < 9; c++) cycle(1, 0, 24'($urandom), 0, 0);
    for (int c = 0; c < 9; c++) cycle(0, 0, 0, 1, 24'($urandom));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // simultaneous push/pop with the FIFO full
    do_reset();
    for (int c = 0; c < 8; c++)  cycle(1, 0, 24'($urandom), 0, 0);
    for (int c = 0; c < 20; c++) cycle(1, 0, 24'($urandom), 1, 24'($urandom));
    for (int c = 0; c < 10; c++) cycle(0, 0, 0, 1, 24'($urandom));
    cycle(0, 0, 0, 0, 0);

    // randomized mix
    do_reset();
    for (int c = 0; c < 3000; c++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, 24'($urandom),
            $urandom_range(0, 3) != 0, 24'($urandom));

    // async reset mid-stream with outstanding tags
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1, 0, 24'($urandom), c == 5, 24'($urandom));
    async_rst();
    cycle(1, 0, 24'h123456, 1, 24'h654321);   // address 0, pop sees empty
    cycle(0, 0, 0, 1, 24'h0BEEF0);            // retires address 0 only
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
